// File: rtl/fifo_ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ex_pkg
//  Description : Shared read-mode constants and width helper for fifo_ex.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_ex_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int usage_w(input int size_e);
        return size_e + 1;
    endfunction

endpackage : fifo_ex_pkg
`default_nettype wire

// File: rtl/fifo_ex_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ex_if
//  Description : Request/status bundle between a FIFO user (master) and fifo_ex (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface fifo_ex_if
    import fifo_ex_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIZE_E = 7
) ();

    logic                          WRITE;
    logic                          READ;
    logic                          CLR_ERR;
    logic [WIDTH-1:0]              D;
    logic [WIDTH-1:0]              Q;
    logic                          EMPTY;
    logic                          FULL;
    logic                          AEMPTY;
    logic                          AFULL;
    logic [usage_w(SIZE_E)-1:0]    USAGE;
    logic                          OVF;
    logic                          UDF;

    modport master (
        output WRITE, READ, CLR_ERR, D,
        input  Q, EMPTY, FULL, AEMPTY, AFULL, USAGE, OVF, UDF
    );

    modport slave (
        input  WRITE, READ, CLR_ERR, D,
        output Q, EMPTY, FULL, AEMPTY, AFULL, USAGE, OVF, UDF
    );

endinterface : fifo_ex_if
`default_nettype wire

// File: rtl/fifo_ex_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ex_mem
//  Description : DEPTH x WIDTH register array, synchronous write, asynchronous read.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_ex_mem #(
    parameter int WIDTH  = 8,
    parameter int SIZE_E = 7
) (
    input  wire logic              CLK,
    input  wire logic              i_we,
    input  wire logic [SIZE_E-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]  i_wdata,
    input  wire logic [SIZE_E-1:0] i_raddr,
    output      logic [WIDTH-1:0]  o_rdata
);

    localparam int c_depth = 2 ** SIZE_E;

    // Contents are deliberately not reset; occupancy tracking makes stale words invisible.
    logic [WIDTH-1:0] r_mem [c_depth];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : fifo_ex_mem
`default_nettype wire

// File: rtl/fifo_ex.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ex
//  Description : Synchronous FIFO with exact occupancy, thresholds, FWFT option, sticky errors.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_ex
    import fifo_ex_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIZE_E    = 7,
    parameter int FWFT      = FIFO_STD,
    parameter int AFULL_TH  = 2 ** SIZE_E - 2,
    parameter int AEMPTY_TH = 2
) (
    input wire logic CLK,
    input wire logic RST,
    fifo_ex_if.slave bus
);

    localparam int                 c_depth     = 2 ** SIZE_E;
    localparam int                 c_uw        = usage_w(SIZE_E);
    localparam logic [c_uw-1:0]    c_usage_max = c_uw'(c_depth);
    localparam logic [c_uw-1:0]    c_usage_one = c_uw'(1);
    localparam logic [c_uw-1:0]    c_afull_th  = c_uw'(AFULL_TH);
    localparam logic [c_uw-1:0]    c_aempty_th = c_uw'(AEMPTY_TH);
    localparam logic [SIZE_E-1:0]  c_ptr_one   = SIZE_E'(1);

    logic [SIZE_E-1:0] r_wr_ptr;
    logic [SIZE_E-1:0] r_rd_ptr;
    logic [c_uw-1:0]   r_usage;
    logic              r_ovf;
    logic              r_udf;
    logic              w_empty;
    logic              w_full;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic [WIDTH-1:0]  w_rdata;

    assign w_empty = (r_usage == '0);
    assign w_full  = (r_usage == c_usage_max);
    assign w_rd_ok = bus.READ & ~w_empty;
    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    assign w_wr_ok = bus.WRITE & (~w_full | w_rd_ok);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_wr_ok && !w_rd_ok) begin
                r_usage <= r_usage + c_usage_one;
            end else if (w_rd_ok && !w_wr_ok) begin
                r_usage <= r_usage - c_usage_one;
            end
            // A new error event in the clearing cycle takes precedence.
            if (bus.WRITE && !w_wr_ok) begin
                r_ovf <= 1'b1;
            end else if (bus.CLR_ERR) begin
                r_ovf <= 1'b0;
            end
            if (bus.READ && !w_rd_ok) begin
                r_udf <= 1'b1;
            end else if (bus.CLR_ERR) begin
                r_udf <= 1'b0;
            end
        end
    end

    fifo_ex_mem #(
        .WIDTH  (WIDTH),
        .SIZE_E (SIZE_E)
    ) u_mem (
        .CLK     (CLK),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.D),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign bus.Q = w_rdata;
        end else begin : g_std
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_q <= '0;
                end else if (w_rd_ok) begin
                    r_q <= w_rdata;
                end
            end

            assign bus.Q = r_q;
        end
    endgenerate

    assign bus.EMPTY  = w_empty;
    assign bus.FULL   = w_full;
    assign bus.AEMPTY = (r_usage <= c_aempty_th);
    assign bus.AFULL  = (r_usage >= c_afull_th);
    assign bus.USAGE  = r_usage;
    assign bus.OVF    = r_ovf;
    assign bus.UDF    = r_udf;

endmodule : fifo_ex
`default_nettype wire

// File: tb/tb_fifo_ex.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_ex
//  Description : Scoreboard bench driving a standard and an FWFT fifo_ex in lockstep.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_ex;
    import fifo_ex_pkg::*;

    localparam int W     = 8;
    localparam int SE    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_ex_if #(.WIDTH(W), .SIZE_E(SE)) bus_std ();
    fifo_ex_if #(.WIDTH(W), .SIZE_E(SE)) bus_fw  ();

    fifo_ex #(.WIDTH(W), .SIZE_E(SE), .FWFT(FIFO_STD), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut_std (
        .CLK (clk),
        .RST (rst),
        .bus (bus_std.slave)
    );

    fifo_ex #(.WIDTH(W), .SIZE_E(SE), .FWFT(FIFO_FWFT), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut_fw (
        .CLK (clk),
        .RST (rst),
        .bus (bus_fw.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a plain queue, sticky flags as bits.
    logic [7:0] m_fifo [$];
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;
    logic [7:0] sb_std [$];
    logic [7:0] m_q_last = 8'h00;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit wr, input bit rd, input logic [7:0] d, input bit clr, input bit r);
        bit rd_ok;
        bit wr_ok;
        bus_std.WRITE = wr;  bus_fw.WRITE = wr;
        bus_std.READ  = rd;  bus_fw.READ  = rd;
        bus_std.D     = d;   bus_fw.D     = d;
        bus_std.CLR_ERR = clr; bus_fw.CLR_ERR = clr;
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            m_fifo.delete();
            sb_std.delete();
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
            m_q_last = 8'h00;
        end else begin
            rd_ok = rd && (m_fifo.size() > 0);
            wr_ok = wr && ((m_fifo.size() < DEPTH) || rd_ok);
            if (rd_ok) sb_std.push_back(m_fifo.pop_front());
            if (wr_ok) m_fifo.push_back(d);
            if (wr && !wr_ok) m_ovf = 1'b1;
            else if (clr)     m_ovf = 1'b0;
            if (rd && !rd_ok) m_udf = 1'b1;
            else if (clr)     m_udf = 1'b0;
        end
    endtask

    // Monitor: compares every DUT output against the model mid-cycle.
    int         mon_n;
    logic [7:0] mon_exp;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_n = m_fifo.size();
            check("usage_std", 32'(bus_std.USAGE), 32'(mon_n));
            check("usage_fwft", 32'(bus_fw.USAGE), 32'(mon_n));
            check("flags_std",
                  {26'd0, bus_std.EMPTY, bus_std.FULL, bus_std.AEMPTY, bus_std.AFULL, bus_std.OVF, bus_std.UDF},
                  {26'd0, mon_n == 0, mon_n == DEPTH, mon_n <= AE, mon_n >= AF, m_ovf, m_udf});
            check("flags_fwft",
                  {26'd0, bus_fw.EMPTY, bus_fw.FULL, bus_fw.AEMPTY, bus_fw.AFULL, bus_fw.OVF, bus_fw.UDF},
                  {26'd0, mon_n == 0, mon_n == DEPTH, mon_n <= AE, mon_n >= AF, m_ovf, m_udf});
            if (sb_std.size() > 0) begin
                mon_exp  = sb_std.pop_front();
                m_q_last = mon_exp;
                check("q_std_pop", 32'(bus_std.Q), 32'(mon_exp));
            end else begin
                check("q_std_hold", 32'(bus_std.Q), 32'(m_q_last));
            end
            if (mon_n > 0) begin
                check("q_fwft", 32'(bus_fw.Q), 32'(m_fifo[0]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(0, 0, 8'h00, 0, 1);
        mon_en = 1'b1;

        // Fill with 0x11..0x88, then overflow.
        for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i * 17), 0, 0);
        cyc(1, 0, 8'hEE, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);

        // Drain, then underflow while Q holds the last word.
        for (int i = 0; i < 8; i++) cyc(0, 1, 8'h00, 0, 0);
        cyc(0, 1, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);

        // Single word into empty, visible without a read, then popped.
        cyc(1, 0, 8'hA5, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 1, 8'h00, 0, 0);

        // Full FIFO with simultaneous read and write.
        for (int i = 0; i < 8; i++) cyc(1, 0, 8'($urandom), 0, 0);
        cyc(1, 1, 8'h99, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 8'h00, 0, 0);

        // Empty FIFO with simultaneous read and write, then error clearing.
        cyc(1, 1, 8'h3C, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        cyc(0, 1, 8'h00, 0, 0);
        cyc(0, 1, 8'h00, 1, 0);
        cyc(0, 0, 8'h00, 0, 0);

        // Reset with five words stored.
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'($urandom), 0, 0);
        cyc(1, 1, 8'h55, 0, 0);
        cyc(0, 0, 8'h00, 0, 1);
        cyc(0, 0, 8'h00, 0, 0);

        // Randomized traffic with alternating write/read bias.
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 60; i++) begin
                cyc(($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 25)),
                    ($urandom_range(0, 99) < ((ph % 2 == 0) ? 25 : 75)),
                    8'($urandom),
                    ($urandom_range(0, 99) < 10),
                    ($urandom_range(0, 199) == 0));
            end
        end

        cyc(0, 0, 8'h00, 0, 0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_ex
`default_nettype wire
